// File: rtl/rice_core_pkg.sv
// Shared types and helpers for the rice bus arbiter and its in-flight ID FIFO.
package rice_core_pkg;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int RICE_BUS_N_MASTERS = 2;
  localparam int RICE_BUS_ID_W      = id_width(RICE_BUS_N_MASTERS);

  typedef logic [RICE_BUS_ID_W-1:0] rice_bus_master_id_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rice_bus_id_fifo.sv
// Synchronous FIFO recording which master issued each in-flight request.
// A push while full is dropped even if a pop happens in the same cycle.
module rice_bus_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (cnt_q == CW'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_head  = mem_q[rd_q];
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = i_push_data;
      wr_d        = nxt(wr_q);
    end
    if (do_pop) rd_d = nxt(rd_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rice_bus_arbiter.sv
// N-master to 1-slave rice bus arbiter; responses return in order via an ID FIFO.
// Define RICE_BUS_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module rice_bus_arbiter
  import rice_core_pkg::*;
#(
  parameter int N_MASTERS       = 2,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic [N_MASTERS-1:0]                       i_m_request_valid,
  output logic [N_MASTERS-1:0]                       o_m_request_ready,
  input  logic [N_MASTERS-1:0][ADDRESS_WIDTH-1:0]    i_m_address,
  input  logic [N_MASTERS-1:0]                       i_m_write,
  input  logic [N_MASTERS-1:0][DATA_WIDTH-1:0]       i_m_write_data,
  input  logic [N_MASTERS-1:0][DATA_WIDTH/8-1:0]     i_m_strobe,
  output logic [N_MASTERS-1:0]                       o_m_response_valid,
  input  logic [N_MASTERS-1:0]                       i_m_response_ready,
  output logic [DATA_WIDTH-1:0]                      o_m_read_data,
  output logic                                       o_m_error,
  output logic                                       o_s_request_valid,
  input  logic                                       i_s_request_ready,
  output logic [ADDRESS_WIDTH-1:0]                   o_s_address,
  output logic                                       o_s_write,
  output logic [DATA_WIDTH-1:0]                      o_s_write_data,
  output logic [DATA_WIDTH/8-1:0]                    o_s_strobe,
  input  logic                                       i_s_response_valid,
  output logic                                       o_s_response_ready,
  input  logic [DATA_WIDTH-1:0]                      i_s_read_data,
  input  logic                                       i_s_error
);
  localparam int IDW = id_width(N_MASTERS);
  typedef logic [IDW-1:0] mid_t;

  arb_state_e state_q, state_d;
  mid_t       lock_id_q, lock_id_d, sel, grant, head;
  logic       sel_hit, gnt_vld, full, empty, req_hs, rsp_hs;

`ifdef RICE_BUS_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    sel     = '0;
    sel_hit = 1'b0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (i_m_request_valid[i]) begin
        sel     = mid_t'(i);
        sel_hit = 1'b1;
      end
    end
  end
`else
  mid_t ptr_q, ptr_d;
  mid_t idx;

  // Search starts one past the last granted master so it goes to the back of the line.
  always_comb begin
    sel     = '0;
    sel_hit = 1'b0;
    idx     = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      idx = mid_t'((int'(ptr_q) + i) % N_MASTERS);
      if (!sel_hit && i_m_request_valid[idx]) begin
        sel     = idx;
        sel_hit = 1'b1;
      end
    end
  end

  assign ptr_d = req_hs ? grant : ptr_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  assign grant   = (state_q == LOCKED) ? lock_id_q : sel;
  assign gnt_vld = (state_q == LOCKED) | sel_hit;

  assign o_s_request_valid = gnt_vld & i_m_request_valid[grant] & ~full;
  assign req_hs            = o_s_request_valid & i_s_request_ready;
  assign o_s_address       = i_m_address[grant];
  assign o_s_write         = i_m_write[grant];
  assign o_s_write_data    = i_m_write_data[grant];
  assign o_s_strobe        = i_m_strobe[grant];

  always_comb begin
    o_m_request_ready = '0;
    if (gnt_vld & i_s_request_ready & ~full) o_m_request_ready[grant] = 1'b1;
  end

  // A stalled grant is frozen so the slave sees a stable payload until it accepts.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE: if (sel_hit && !req_hs) begin
        state_d   = LOCKED;
        lock_id_d = sel;
      end
      LOCKED:  if (req_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  rice_bus_id_fifo #(
    .WIDTH (IDW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (req_hs),
    .i_push_data (grant),
    .i_pop       (rsp_hs),
    .o_full      (full),
    .o_empty     (empty),
    .o_head      (head)
  );

  assign o_s_response_ready = ~empty & i_m_response_ready[head];
  assign rsp_hs             = i_s_response_valid & o_s_response_ready;
  assign o_m_read_data      = i_s_read_data;
  assign o_m_error          = i_s_error;

  always_comb begin
    o_m_response_valid = '0;
    if (~empty & i_s_response_valid) o_m_response_valid[head] = 1'b1;
  end

endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Bench for rice_bus_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_rice_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MO = 2;

  logic                   i_clk, i_rst;
  logic [N-1:0]           i_m_request_valid, o_m_request_ready, i_m_write;
  logic [N-1:0][AW-1:0]   i_m_address;
  logic [N-1:0][DW-1:0]   i_m_write_data;
  logic [N-1:0][SW-1:0]   i_m_strobe;
  logic [N-1:0]           o_m_response_valid, i_m_response_ready;
  logic [DW-1:0]          o_m_read_data, i_s_read_data, o_s_write_data;
  logic                   o_m_error, o_s_request_valid, i_s_request_ready, o_s_write;
  logic [AW-1:0]          o_s_address;
  logic [SW-1:0]          o_s_strobe;
  logic                   i_s_response_valid, o_s_response_ready, i_s_error;

  rice_bus_arbiter #(
    .N_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m_request_valid(i_m_request_valid), .o_m_request_ready(o_m_request_ready),
    .i_m_address(i_m_address), .i_m_write(i_m_write), .i_m_write_data(i_m_write_data),
    .i_m_strobe(i_m_strobe), .o_m_response_valid(o_m_response_valid),
    .i_m_response_ready(i_m_response_ready), .o_m_read_data(o_m_read_data),
    .o_m_error(o_m_error), .o_s_request_valid(o_s_request_valid),
    .i_s_request_ready(i_s_request_ready), .o_s_address(o_s_address),
    .o_s_write(o_s_write), .o_s_write_data(o_s_write_data), .o_s_strobe(o_s_strobe),
    .i_s_response_valid(i_s_response_valid), .o_s_response_ready(o_s_response_ready),
    .i_s_read_data(i_s_read_data), .i_s_error(i_s_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks, passes;
  int q[$];          // master index of each outstanding request, oldest first
  int ptr_m, lk_id, g, last_hs;
  bit lk, has, exp_sv, exp_srr;
  int hist[8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    q.delete();
    ptr_m = 0;
    lk    = 0;
    lk_id = 0;
  endtask

  // Expected outputs from the current inputs and model state, compared against the DUT.
  task automatic eval();
    logic [N-1:0] er, ev;
    int h, idx;
    bit full, empty;
    #1;
    has = 0;
    g   = 0;
    if (lk) begin
      has = 1;
      g   = lk_id;
    end else begin
      for (int k = 1; k <= N; k++) begin
`ifdef RICE_BUS_ARBITER_FIXED_PRIORITY_EN
        idx = k - 1;
`else
        idx = (ptr_m + k) % N;
`endif
        if (!has && i_m_request_valid[idx]) begin
          g   = idx;
          has = 1;
        end
      end
    end
    full    = (q.size() == MO);
    empty   = (q.size() == 0);
    exp_sv  = has && i_m_request_valid[g] && !full;
    er      = '0;
    if (has && i_s_request_ready && !full) er[g] = 1'b1;
    h       = empty ? 0 : q[0];
    ev      = '0;
    if (!empty && i_s_response_valid) ev[h] = 1'b1;
    exp_srr = !empty && i_m_response_ready[h];
    chk("s_req_valid", o_s_request_valid, exp_sv);
    chk("m_req_ready", o_m_request_ready, er);
    chk("s_address", o_s_address, i_m_address[g]);
    chk("s_write", o_s_write, i_m_write[g]);
    chk("s_wdata", o_s_write_data, i_m_write_data[g]);
    chk("s_strobe", o_s_strobe, i_m_strobe[g]);
    chk("m_rsp_valid", o_m_response_valid, ev);
    chk("s_rsp_ready", o_s_response_ready, exp_srr);
    chk("m_rdata", o_m_read_data, i_s_read_data);
    chk("m_error", o_m_error, i_s_error);
  endtask

  task automatic tick();
    bit req_hs, rsp_hs;
    req_hs = exp_sv && i_s_request_ready;
    rsp_hs = i_s_response_valid && exp_srr;
    @(posedge i_clk);
    last_hs = -1;
    if (i_rst) model_clear();
    else begin
      if (rsp_hs) void'(q.pop_front());
      if (req_hs) begin
        q.push_back(g);
        ptr_m   = g;
        lk      = 0;
        last_hs = g;
      end else if (has) begin
        lk    = 1;
        lk_id = g;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic new_req(input int m);
    i_m_request_valid[m] = 1'b1;
    i_m_address[m]       = $urandom;
    i_m_write[m]         = 1'($urandom_range(0, 1));
    i_m_write_data[m]    = $urandom;
    i_m_strobe[m]        = SW'($urandom_range(0, (1 << SW) - 1));
  endtask

  task automatic rand_masters();
    for (int m = 0; m < N; m++) begin
      if (last_hs == m) i_m_request_valid[m] = 1'b0;
      if (!i_m_request_valid[m] && $urandom_range(0, 2) != 0) new_req(m);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    model_clear();
    eval();
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    checks = 0; passes = 0; last_hs = -1;
    i_rst = 1'b1;
    i_m_request_valid = '0; i_m_write = '0; i_m_address = '0; i_m_write_data = '0;
    i_m_strobe = '0; i_m_response_ready = '0; i_s_request_ready = 1'b0;
    i_s_response_valid = 1'b0; i_s_read_data = '0; i_s_error = 1'b0;
    model_clear();

    // Reset with everything idle
    @(negedge i_clk);
    eval();
    chk("rst_s_valid", o_s_request_valid, 0);
    chk("rst_m_ready", o_m_request_ready, 0);
    chk("rst_m_rsp_valid", o_m_response_valid, 0);
    chk("rst_s_rsp_ready", o_s_response_ready, 0);
    tick();
    i_rst = 1'b0;
    eval();
    tick();

    // Both masters requesting continuously, slave always ready
    new_req(0); new_req(1);
    i_s_request_ready = 1'b1; i_s_response_valid = 1'b1; i_m_response_ready = '1;
    for (int c = 0; c < 8; c++) begin
      i_s_read_data = $urandom;
      eval();
      tick();
      hist[c] = last_hs;
      if (last_hs >= 0) new_req(last_hs);
    end
`ifdef RICE_BUS_ARBITER_FIXED_PRIORITY_EN
    for (int c = 0; c < 8; c++) chk("fixed_prio_win", hist[c], 0);
`else
    chk("rr_first", hist[0], 1);
    for (int c = 1; c < 8; c++) chk("rr_alternate", hist[c], 1 - hist[c-1]);
`endif

    // Stalled grant on master 1 holds while master 0 joins
    do_reset();
    i_m_request_valid = '0; i_s_request_ready = 1'b0; i_s_response_valid = 1'b0;
    new_req(1);
    i_m_address[1] = 32'h100;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) new_req(0);
      i_s_request_ready = (c == 3);
      eval();
      chk("lock_addr", o_s_address, 32'h100);
      chk("lock_rdy0", o_m_request_ready[0], 0);
      tick();
    end
    chk("lock_hs_m1", last_hs, 1);
    i_m_request_valid[1] = 1'b0;
    eval();
    tick();
    i_m_request_valid = '0;

    // FIFO full: third request stalls; response and request in the same cycle
    do_reset();
    i_s_response_valid = 1'b0; i_s_error = 1'b0; i_m_response_ready = '1;
    i_s_request_ready = 1'b1;
    new_req(0);
    for (int c = 0; c < 4; c++) begin
      eval();
      if (c >= 2) chk("full_stall", o_s_request_valid, 0);
      tick();
      if (last_hs == 0) new_req(0);
    end
    i_s_response_valid = 1'b1; i_s_error = 1'b1; i_s_read_data = 32'hdead_beef;
    eval();
    chk("full_rsp_stall", o_s_request_valid, 0);
    chk("err_valid", o_m_response_valid, 2'b01);
    chk("err_flag", o_m_error, 1);
    tick();
    i_s_response_valid = 1'b0; i_s_error = 1'b0;
    eval();
    chk("post_pop_req", o_s_request_valid, 1);
    tick();

    // Random traffic with a mid-run reset
    i_m_request_valid = '0;
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        i_rst = 1'b1;
        model_clear();
      end else if (c == 302) begin
        i_rst = 1'b0;
      end
      i_s_request_ready  = 1'($urandom_range(0, 1));
      i_s_response_valid = 1'($urandom_range(0, 1));
      i_s_error          = 1'($urandom_range(0, 1));
      i_s_read_data      = $urandom;
      i_m_response_ready = N'($urandom_range(0, (1 << N) - 1));
      eval();
      tick();
      rand_masters();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
